// File: rtl/sccb_pkg.sv
// Shared constants, state encoding and register-table contents for the
// SCCB camera initialisation sequencer.
package sccb_pkg;

    localparam int          ENTRY_W          = 16;
    localparam int          INDEX_W          = 8;
    localparam int          TABLE_DEPTH      = 256;
    localparam logic [15:0] END_MARKER       = 16'hFFFF;
    localparam logic [7:0]  DELAY_REG        = 8'hFE;
    localparam logic [6:0]  DEFAULT_DEV_ADDR = 7'h21;
    localparam int          GAP_CYCLES       = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DELAY,
        ST_FINISH,
        ST_FAIL
    } state_t;

    // Table 0 is the camera bring-up list; table 1 fills all 256 slots with
    // writes and has no end marker, exercising the index-wrap finish.
    function automatic logic [ENTRY_W-1:0] table_entry(input int table_id, input int index);
        logic [7:0] idx8;
        idx8 = 8'(index);
        if (table_id == 1) begin
            return {1'b0, idx8[6:0], idx8};
        end
        case (index)
            0:       return 16'h1280;
            1:       return 16'hFE02;
            2:       return 16'h1101;
            3:       return 16'h3A04;
            4:       return 16'hFE00;
            5:       return 16'h40D0;
            default: return END_MARKER;
        endcase
    endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Constant 256x16 register table with a registered (one-cycle) read port.
module sccb_init_rom
    import sccb_pkg::*;
#(
    parameter int TABLE_ID = 0
) (
    input  logic               clk,
    input  logic [INDEX_W-1:0] index,
    output logic [ENTRY_W-1:0] entry
);

    logic [ENTRY_W-1:0] rom_mem [TABLE_DEPTH];

    generate
        for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_rom
            assign rom_mem[gi] = table_entry(TABLE_ID, gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        entry <= rom_mem[index];
    end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the register table on START, issuing SCCB writes with retry on NACK
// and millisecond delays, then reports DONE or ERROR.
module sccb_init_sequencer
    import sccb_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 25_000_000,
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         MAX_RETRY   = 3,
    parameter int         TABLE_ID    = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic               SEL,
    output logic               RW,
    output logic [6:0]         ADDR,
    output logic [7:0]         REG_ADDR,
    output logic [7:0]         DATA_IN,
    input  logic               SCCB_DONE,
    input  logic               SCCB_NACK,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERROR,
    output logic [INDEX_W-1:0] ERR_INDEX
);

    localparam logic [31:0] TICKS_PER_MS = 32'(CLK_FREQ_HZ / 1000);
    localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRY);
    localparam logic [4:0]  GAP_LAST     = 5'(GAP_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [INDEX_W-1:0] index_reg, index_next;
    logic [7:0]         retry_reg, retry_next;
    logic [31:0]        delay_reg, delay_next;
    logic [4:0]         gap_reg, gap_next;
    logic               sel_reg, sel_next;
    logic [7:0]         reg_addr_reg, reg_addr_next;
    logic [7:0]         data_reg, data_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               error_reg, error_next;
    logic [INDEX_W-1:0] err_index_reg, err_index_next;
    logic [ENTRY_W-1:0] entry;
    logic               at_last_index;

    sccb_init_rom #(
        .TABLE_ID(TABLE_ID)
    ) u_rom (
        .clk  (CLK),
        .index(index_reg),
        .entry(entry)
    );

    assign at_last_index = (index_reg == '1);

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        retry_next     = retry_reg;
        delay_next     = delay_reg;
        gap_next       = gap_reg;
        sel_next       = sel_reg;
        reg_addr_next  = reg_addr_reg;
        data_next      = data_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        error_next     = error_reg;
        err_index_next = err_index_reg;

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    index_next = '0;
                    retry_next = '0;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    busy_next  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_DECODE;
            ST_DECODE: begin
                if (entry == END_MARKER) begin
                    state_next = ST_FINISH;
                end else if (entry[15:8] == DELAY_REG) begin
                    if (entry[7:0] == 8'd0) begin
                        // zero-length delay skips straight to the next entry
                        if (at_last_index) begin
                            state_next = ST_FINISH;
                        end else begin
                            index_next = index_reg + 8'd1;
                            state_next = ST_FETCH;
                        end
                    end else begin
                        delay_next = 32'(entry[7:0]) * TICKS_PER_MS - 32'd1;
                        state_next = ST_DELAY;
                    end
                end else begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sel_next      = 1'b1;
                reg_addr_next = entry[15:8];
                data_next     = entry[7:0];
                state_next    = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (SCCB_DONE) begin
                    sel_next = 1'b0;
                    if (!SCCB_NACK) begin
                        retry_next = '0;
                        if (at_last_index) begin
                            state_next = ST_FINISH;
                        end else begin
                            index_next = index_reg + 8'd1;
                            state_next = ST_FETCH;
                        end
                    end else if (retry_reg < RETRY_LIMIT) begin
                        retry_next = retry_reg + 8'd1;
                        gap_next   = '0;
                        state_next = ST_GAP;
                    end else begin
                        err_index_next = index_reg;
                        state_next     = ST_FAIL;
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = ST_ISSUE;
                end else begin
                    gap_next = gap_reg + 5'd1;
                end
            end
            ST_DELAY: begin
                if (delay_reg == 32'd0) begin
                    if (at_last_index) begin
                        state_next = ST_FINISH;
                    end else begin
                        index_next = index_reg + 8'd1;
                        state_next = ST_FETCH;
                    end
                end else begin
                    delay_next = delay_reg - 32'd1;
                end
            end
            ST_FINISH: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            ST_FAIL: begin
                error_next = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= ST_IDLE;
            index_reg     <= '0;
            retry_reg     <= '0;
            delay_reg     <= '0;
            gap_reg       <= '0;
            sel_reg       <= 1'b0;
            reg_addr_reg  <= '0;
            data_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            err_index_reg <= '0;
        end else begin
            state_reg     <= state_next;
            index_reg     <= index_next;
            retry_reg     <= retry_next;
            delay_reg     <= delay_next;
            gap_reg       <= gap_next;
            sel_reg       <= sel_next;
            reg_addr_reg  <= reg_addr_next;
            data_reg      <= data_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            err_index_reg <= err_index_next;
        end
    end

    assign SEL       = sel_reg;
    assign RW        = 1'b0;
    assign ADDR      = DEV_ADDR;
    assign REG_ADDR  = reg_addr_reg;
    assign DATA_IN   = data_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign ERROR     = error_reg;
    assign ERR_INDEX = err_index_reg;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench: a table-walking reference model queues expected writes,
// NACK responses and outcomes; monitors compare what the sequencer presents.
module tb_sccb_init_sequencer;

    localparam int MAX_RETRY     = 3;
    localparam int TICKS         = 1;
    localparam int NEXT_GAP_LOW  = 3;   // FETCH, DECODE, ISSUE
    localparam int RETRY_GAP_LOW = 17;  // 16 gap cycles plus ISSUE

    typedef struct { logic [7:0] reg_a; logic [7:0] val; int gap; } xfer_t;
    typedef struct { logic done; logic error; logic [7:0] idx; } outcome_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, sccb_done, sccb_nack;
    logic       sel, rw, busy, done, error;
    logic [6:0] addr;
    logic [7:0] reg_addr, data_in, err_index;

    logic       start_w, ack_w;
    logic       sel_w, rw_w, busy_w, done_w, error_w;
    logic [6:0] addr_w;
    logic [7:0] reg_w, data_w, erri_w;

    int n_vec = 0;
    int n_err = 0;

    xfer_t    exp_q[$];
    logic     nack_q[$];
    outcome_t out_q[$];
    xfer_t    wexp_q[$];
    int       plan[256];
    bit       master_hold = 1'b0;
    int       wcount = 0;

    sccb_init_sequencer #(
        .CLK_FREQ_HZ(1000), .DEV_ADDR(7'h21), .MAX_RETRY(MAX_RETRY), .TABLE_ID(0)
    ) u_dut (
        .CLK(clk), .RST(rst), .START(start), .SEL(sel), .RW(rw), .ADDR(addr),
        .REG_ADDR(reg_addr), .DATA_IN(data_in), .SCCB_DONE(sccb_done),
        .SCCB_NACK(sccb_nack), .BUSY(busy), .DONE(done), .ERROR(error),
        .ERR_INDEX(err_index)
    );

    sccb_init_sequencer #(
        .CLK_FREQ_HZ(1000), .DEV_ADDR(7'h21), .MAX_RETRY(MAX_RETRY), .TABLE_ID(1)
    ) u_wrap (
        .CLK(clk), .RST(rst), .START(start_w), .SEL(sel_w), .RW(rw_w), .ADDR(addr_w),
        .REG_ADDR(reg_w), .DATA_IN(data_w), .SCCB_DONE(ack_w), .SCCB_NACK(1'b0),
        .BUSY(busy_w), .DONE(done_w), .ERROR(error_w), .ERR_INDEX(erri_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_entry(input int i);
        logic [15:0] tbl [7] = '{16'h1280, 16'hFE02, 16'h1101, 16'h3A04,
                                 16'hFE00, 16'h40D0, 16'hFFFF};
        if (i < 7) return tbl[i];
        return 16'hFFFF;
    endfunction

    // Walk the table as written: each write is attempted until ACKed or the
    // retry budget is spent; delays only lengthen the idle gap before the next SEL.
    task automatic build_model();
        int          gap;
        logic [15:0] e;
        bit          ended;
        xfer_t       x;
        outcome_t    o;
        gap = NEXT_GAP_LOW;
        ended = 1'b0;
        for (int i = 0; i < 256 && !ended; i++) begin
            e = ref_entry(i);
            if (e == 16'hFFFF) begin
                o.done = 1'b1; o.error = 1'b0; o.idx = 8'h00;
                out_q.push_back(o);
                ended = 1'b1;
            end else if (e[15:8] == 8'hFE) begin
                gap += 2 + int'(e[7:0]) * TICKS;
            end else begin
                for (int a = 0; a <= MAX_RETRY; a++) begin
                    x.reg_a = e[15:8]; x.val = e[7:0];
                    x.gap = (a == 0) ? gap : RETRY_GAP_LOW;
                    exp_q.push_back(x);
                    if (a < plan[i]) begin
                        nack_q.push_back(1'b1);
                        if (a == MAX_RETRY) begin
                            o.done = 1'b0; o.error = 1'b1; o.idx = 8'(i);
                            out_q.push_back(o);
                            ended = 1'b1;
                        end
                    end else begin
                        nack_q.push_back(1'b0);
                        break;
                    end
                end
                gap = NEXT_GAP_LOW;
            end
        end
        if (!ended) begin
            o.done = 1'b1; o.error = 1'b0; o.idx = 8'h00;
            out_q.push_back(o);
        end
    endtask

    // SCCB master stand-in: random response latency, plus stray DONE pulses
    // while no transfer is requested.
    initial begin
        int wait_n;
        wait_n = 1;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        forever begin
            @(posedge clk); #2;
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (sel === 1'b1 && !rst && !master_hold) begin
                if (wait_n == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                    wait_n = $urandom_range(3, 0);
                end else begin
                    wait_n--;
                end
            end else if (sel === 1'b0 && !rst && !master_hold && $urandom_range(7, 0) == 0) begin
                sccb_done = 1'b1;
                sccb_nack = 1'b1;
            end
        end
    end

    initial begin
        ack_w = 1'b0;
        forever begin
            @(posedge clk); #2;
            ack_w = (sel_w === 1'b1) && !ack_w;
        end
    end

    int       low_cnt = 0;
    bit       evt = 1'b0, prev_sel = 1'b0, prev_busy = 1'b0;
    logic [7:0] cur_reg, cur_val;
    xfer_t    mx;
    outcome_t mo;

    always @(negedge clk) begin
        if (rst) begin
            evt = 1'b0; prev_sel = 1'b0; prev_busy = 1'b0; low_cnt = 0;
        end else begin
            if (evt) low_cnt = 0;
            if (sel && !prev_sel) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sel", 1, 0);
                end else begin
                    mx = exp_q.pop_front();
                    chk("reg_addr", reg_addr, mx.reg_a);
                    chk("data_in", data_in, mx.val);
                    chk("sel_low_gap", low_cnt, mx.gap);
                    chk("rw", rw, 0);
                    chk("addr", addr, 7'h21);
                    $display("xfer reg=%02h val=%02h gap=%0d", reg_addr, data_in, low_cnt);
                end
                cur_reg = reg_addr;
                cur_val = data_in;
            end else if (sel) begin
                chk("sel_hold", {reg_addr, data_in}, {cur_reg, cur_val});
            end else begin
                low_cnt++;
            end
            if (prev_busy && !busy) begin
                if (out_q.size() == 0) begin
                    chk("unexpected_busy_fall", 1, 0);
                end else begin
                    mo = out_q.pop_front();
                    chk("done", done, mo.done);
                    chk("error", error, mo.error);
                    if (mo.error) chk("err_index", err_index, mo.idx);
                    $display("outcome done=%0b error=%0b idx=%0d", done, error, err_index);
                end
            end
            evt = (sel && sccb_done) || (start && !busy);
            prev_sel = sel;
            prev_busy = busy;
        end
    end

    bit prev_sel_w = 1'b0;
    xfer_t wx;
    always @(negedge clk) begin
        if (!rst && sel_w && !prev_sel_w) begin
            if (wexp_q.size() == 0) begin
                chk("wrap_unexpected_sel", 1, 0);
            end else begin
                wx = wexp_q.pop_front();
                chk("wrap_reg_data", {reg_w, data_w}, {wx.reg_a, wx.val});
            end
            wcount++;
        end
        prev_sel_w = rst ? 1'b0 : sel_w;
    end

    task automatic wait_idle(input int limit);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < limit && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    task automatic run_seq(input bit dup_start);
        build_model();
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("error_cleared", error, 0);
        fork
            wait_idle(3000);
            begin
                if (dup_start) begin
                    repeat ($urandom_range(30, 3)) @(posedge clk);
                    #2;
                    if (busy) begin
                        start = 1'b1;
                        @(posedge clk); #2;
                        start = 1'b0;
                    end
                end
            end
        join
        repeat (25) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("outcomes_drained", out_q.size(), 0);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 256; i++) plan[i] = 0;
    endtask

    initial begin
        bit got_sel;
        xfer_t x;
        rst = 1'b1; start = 1'b0; start_w = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_rw", rw, 0);
        chk("rst_addr", addr, 7'h21);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_index", err_index, 0);
        @(posedge clk); #2; rst = 1'b0;

        clear_plan();                run_seq(1'b0);   // all ACK
        clear_plan(); plan[2] = 2;   run_seq(1'b0);   // two NACKs then ACK
        clear_plan(); plan[2] = 4;   run_seq(1'b0);   // retries exhausted
        clear_plan(); plan[5] = 3;   run_seq(1'b0);   // ACK on the final attempt
        for (int r = 0; r < 6; r++) begin
            clear_plan();
            for (int i = 0; i < 8; i++)
                plan[i] = ($urandom_range(2, 0) == 0) ? $urandom_range(4, 0) : 0;
            run_seq(1'b1);
        end

        // Reset while a transfer is outstanding.
        master_hold = 1'b1;
        x.reg_a = 8'h12; x.val = 8'h80; x.gap = NEXT_GAP_LOW;
        exp_q.push_back(x);
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        got_sel = 1'b0;
        for (int c = 0; c < 50 && !got_sel; c++) begin
            @(negedge clk);
            if (sel) got_sel = 1'b1;
        end
        chk("rst_test_sel_seen", got_sel, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        @(negedge clk);
        chk("midrst_sel", sel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_error", error, 0);
        chk("midrst_reg_addr", reg_addr, 0);
        exp_q.delete(); nack_q.delete(); out_q.delete();
        master_hold = 1'b0;
        clear_plan(); run_seq(1'b0);

        // Table without end marker: every slot written, then finish on wrap.
        for (int i = 0; i < 256; i++) begin
            x.reg_a = 8'(i & 8'h7F); x.val = 8'(i); x.gap = 0;
            wexp_q.push_back(x);
        end
        @(posedge clk); #2; start_w = 1'b1;
        @(posedge clk); #2; start_w = 1'b0;
        got_sel = 1'b0;
        for (int c = 0; c < 5000 && !got_sel; c++) begin
            @(negedge clk);
            if (!busy_w) got_sel = 1'b1;
        end
        chk("wrap_finished", got_sel, 1);
        chk("wrap_write_count", wcount, 256);
        chk("wrap_done", done_w, 1);
        chk("wrap_error", error_w, 0);
        chk("wrap_drained", wexp_q.size(), 0);
        $display("wrap writes=%0d done=%0b", wcount, done_w);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
